// File: rtl/collision_rule_engine.sv
// collision_rule_engine
//   Evaluates NUM_RULES programmable collision rules over NUM_OBJ drawing
//   requests every pixel clock. Each rule pulses at most once per frame,
//   the previous frame's hits are summarised in frame_hits, and per-rule
//   saturating counters record how many frames each rule hit in.
//
// Ports
//   clk, reset        pixel clock, synchronous active-high reset
//   startOfFrame      one-cycle pulse that closes the current frame
//   drawing_request   per-object request for the current pixel
//   rule_enable       per-rule enable (masks new matches only)
//   clear_counts      synchronous clear of all hit counters
//   collision         combinational: two or more objects requesting
//   SingleHitPulse    one pulse per frame on the first general collision
//   rule_pulse        per-rule single pulse (in-frame or deferred)
//   frame_hits        rules that hit during the previous frame
//   hit_count         per-rule saturating counters, rule r at [r*CNT_W +: CNT_W]
//   staticObjectReq   registered OR of requests from static scenery objects
module collision_rule_engine #(
    parameter int                             NUM_OBJ     = 12,
    parameter int                             NUM_RULES   = 12,
    parameter int                             CNT_W       = 8,
    parameter logic [NUM_RULES*NUM_OBJ-1:0]   RULE_REQ    = '0,
    parameter logic [NUM_RULES*NUM_OBJ-1:0]   RULE_EXCL   = '0,
    parameter logic [NUM_RULES-1:0]           RULE_ANY    = '0,
    parameter logic [NUM_OBJ-1:0]             STATIC_MASK = '0,
    parameter bit                             DEFER_MODE  = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic [NUM_OBJ-1:0]           drawing_request,
    input  logic [NUM_RULES-1:0]         rule_enable,
    input  logic                         clear_counts,
    output logic                         collision,
    output logic                         SingleHitPulse,
    output logic [NUM_RULES-1:0]         rule_pulse,
    output logic [NUM_RULES-1:0]         frame_hits,
    output logic [NUM_RULES*CNT_W-1:0]   hit_count,
    output logic                         staticObjectReq
);

    logic [NUM_RULES-1:0]       flag_q, flag_d;
    logic [NUM_RULES-1:0]       pulse_q, pulse_d;
    logic [NUM_RULES-1:0]       fhits_q, fhits_d;
    logic [NUM_RULES*CNT_W-1:0] cnt_q, cnt_d;
    logic                       gflag_q, gflag_d;
    logic                       single_q, single_d;
    logic                       static_q, static_d;
    logic [NUM_RULES-1:0]       match;

    // Two-or-more detector without a full popcount: a second set bit
    // seen after the first one is all that matters.
    always_comb begin
        logic seen_one;
        logic seen_two;
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (drawing_request[i]) begin
                if (seen_one) seen_two = 1'b1;
                seen_one = 1'b1;
            end
        end
        collision = seen_two;
    end

    always_comb begin
        logic [NUM_OBJ-1:0] req_r;
        logic [NUM_OBJ-1:0] excl_r;
        match  = '0;
        req_r  = '0;
        excl_r = '0;
        for (int r = 0; r < NUM_RULES; r++) begin
            req_r    = RULE_REQ[r*NUM_OBJ +: NUM_OBJ];
            excl_r   = RULE_EXCL[r*NUM_OBJ +: NUM_OBJ];
            // An all-zero rule (no required objects, no collision term)
            // would match every pixel; treat it as an empty slot instead.
            match[r] = rule_enable[r]
                     & ((drawing_request & req_r) == req_r)
                     & ((drawing_request & excl_r) == '0)
                     & (!RULE_ANY[r] | collision)
                     & ((req_r != '0) | RULE_ANY[r]);
        end
    end

    always_comb begin
        logic [CNT_W-1:0] cnt_cur;
        cnt_cur  = '0;
        cnt_d    = cnt_q;

        // The startOfFrame cycle opens the new frame, so its own match
        // lands in the freshly cleared flags.
        flag_d   = (startOfFrame ? '0 : flag_q) | match;
        gflag_d  = (startOfFrame ? 1'b0 : gflag_q) | collision;
        single_d = collision & (!gflag_q | startOfFrame);

        if (DEFER_MODE) pulse_d = startOfFrame ? flag_q : '0;
        else            pulse_d = match & (~flag_q | {NUM_RULES{startOfFrame}});

        fhits_d  = startOfFrame ? flag_q : fhits_q;
        static_d = |(drawing_request & STATIC_MASK);

        for (int r = 0; r < NUM_RULES; r++) begin
            cnt_cur = cnt_q[r*CNT_W +: CNT_W];
            if (clear_counts)
                cnt_cur = '0;
            else if (startOfFrame && flag_q[r] && (cnt_cur != '1))
                cnt_cur = cnt_cur + {{(CNT_W-1){1'b0}}, 1'b1};
            cnt_d[r*CNT_W +: CNT_W] = cnt_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q   <= '0;
            pulse_q  <= '0;
            fhits_q  <= '0;
            cnt_q    <= '0;
            gflag_q  <= 1'b0;
            single_q <= 1'b0;
            static_q <= 1'b0;
        end else begin
            flag_q   <= flag_d;
            pulse_q  <= pulse_d;
            fhits_q  <= fhits_d;
            cnt_q    <= cnt_d;
            gflag_q  <= gflag_d;
            single_q <= single_d;
            static_q <= static_d;
        end
    end

    assign SingleHitPulse  = single_q;
    assign rule_pulse      = pulse_q;
    assign frame_hits      = fhits_q;
    assign hit_count       = cnt_q;
    assign staticObjectReq = static_q;

endmodule
